t02_mem_arbiter: RTL and testbench
==================================

// Module: t02_mem_arbiter
// PURPOSE
//  Shares the single external RAM/wishbone port (ramaddr/ramstore/Ren/Wen/sel_i/busy_o) between requesters:
//  port 0 = FPGA loader/keypad module (strict priority), ports 1..N_PORTS-1 = CPU data and instruction fetch.
//  Port 0 wins every arbitration; ports 1..N_PORTS-1 are served round-robin.
//  One transaction is outstanding at a time. Read data is latched and returned with a one-cycle done pulse.
//  A hung bus (busy_o stuck high) is detected and the transaction is aborted with an error flag.
// PARAMETERS
//  N_PORTS    3    number of requesters (>=2); port 0 is priority port
//  TIMEOUT    255  max cycles in WAIT before abort (8-bit counter, saturates)
// PORTS
//  clk          in   1           system clock
//  nrst         in   1           async active-low reset
//  m_req        in   N_PORTS     request; held high with operands stable until m_done
//  m_we         in   N_PORTS     1=write, 0=read
//  m_addr       in   N_PORTS*32  byte address, port i at [32*i+:32]
//  m_wdata      in   N_PORTS*32  write data, same packing
//  m_sel        in   N_PORTS*4   byte selects, port i at [4*i+:4]
//  m_done       out  N_PORTS     one-cycle completion pulse to owning port
//  m_rdata      out  32          read data, valid in the m_done cycle and held until next completion
//  bus_ren      out  1           to Ren
//  bus_wen      out  1           to Wen
//  bus_addr     out  32          to ramaddr
//  bus_wdata    out  32          to ramstore
//  bus_sel      out  4           to sel_i
//  bus_rdata    in   32          from ramload
//  busy_o       in   1           bus busy from wishbone manager
//  gnt_id       out  2           index of current/last granted port
//  timeout_err  out  1           sticky; set on abort, cleared only by reset
// BEHAVIOUR
//  - Reset: clk domain, async active-low nrst; all outputs 0, state IDLE, rr pointer = 1, m_rdata = 0.
//  - FSM IDLE -> ISSUE -> SETTLE -> WAIT -> DONE -> IDLE.
//  - IDLE: if any m_req, grant = 0 if m_req[0], else first requesting port at or after rr pointer
//    (wrapping N_PORTS-1 -> 1). Latch addr/wdata/sel/we of granted port into bus regs; go ISSUE.
//  - ISSUE (1 cycle): bus_ren = ~we or bus_wen = we, exactly one asserted; go SETTLE.
//  - SETTLE (1 cycle): strobes low, busy_o ignored (manager latency).
//  - WAIT: stay while busy_o=1; count cycles.
//    - busy_o=0: capture bus_rdata into m_rdata (reads only; writes leave m_rdata unchanged); go DONE.
//    - count reaches TIMEOUT: set timeout_err, m_rdata = 32'hDEAD_BEEF; go DONE.
//  - DONE (1 cycle): m_done[gnt]=1; if gnt!=0, rr pointer = gnt+1 (wrap to 1); go IDLE.
//  - Latency: idle bus, busy_o low after 1 cycle -> m_done 4 cycles after m_req seen in IDLE.
//  - Request dropping mid-transaction is ignored; the transaction completes and m_done pulses.
//  - The requester must deassert m_req or present a new op on the cycle after m_done;
//    IDLE re-arbitrates immediately (back-to-back allowed).
//  - bus_addr/bus_wdata/bus_sel are stable from ISSUE through DONE. Inputs are never combinationally passed to the bus.
//  - Simultaneous requests on all ports: port 0 first, then rr order. A port held continuously
//    by port 0 can starve the others (intentional: loader mode).
//  - gnt_id updates in IDLE on grant; holds otherwise.
//  - nrst mid-transaction: immediate return to IDLE. Strobes drop asynchronously. No m_done is issued.
// STRUCTURE
//  - t02_pkg: typedef enum logic [2:0] {ARB_IDLE, ARB_ISSUE, ARB_SETTLE, ARB_WAIT, ARB_DONE} arb_state_t;
//    localparam ARB_ERR_DATA = 32'hDEAD_BEEF.
//  - Sub-module t02_rr_picker: combinational round-robin select (req vector, pointer -> one-hot grant + index).
//  - Everything else (FSM, timeout counter, bus registers) lives in this module.
// TESTING
//  1. Single read, port 1, addr 0x0000_0040, busy_o high 3 cycles, bus_rdata=0x1234_5678
//     -> bus_ren one cycle, m_done[1] once, m_rdata=0x1234_5678.
//  2. Write, port 2, addr 0x80, wdata 0xCAFE_F00D, sel 4'b1111 -> bus_wen one cycle,
//     bus_addr/wdata/sel held until done, m_done[2] once, bus_ren never high.
//  3. Ports 0,1,2 request together -> grant order 0,1,2; then ports 1,2 only -> alternating 1,2,1,2.
//  4. busy_o stuck high -> m_done after TIMEOUT WAIT cycles; timeout_err=1 and stays 1;
//     m_rdata=0xDEAD_BEEF; next request still served.
//  5. nrst asserted in WAIT -> all outputs 0 the same cycle, no m_done.
//     Post-reset, port 1 request completes normally.
//  6. Back-to-back: port 1 re-requests the cycle after m_done -> served again within 4 cycles;
//     m_rdata is held between completions.

Source files
------------

// File: rtl/t02_pkg.sv
// Shared types and constants for the t02 memory arbiter: FSM encoding,
// abort data pattern and the round-robin pointer advance rule.
package t02_pkg;

   typedef enum logic [2:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_SETTLE,
      ARB_WAIT,
      ARB_DONE
   } arb_state_t;

   localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;
   localparam int          ARB_CNT_W    = 8;

   // Port 0 never takes part in round-robin, so the wrap goes back to 1.
   function automatic logic [1:0] rr_next(input logic [1:0] idx, input int n_ports);
      if (int'(idx) >= n_ports - 1) begin
         return 2'd1;
      end
      return idx + 2'd1;
   endfunction

endpackage

// File: rtl/t02_rr_picker.sv
// Combinational round-robin select over the shared ports 1..N_PORTS-1,
// searching upward from ptr and wrapping from N_PORTS-1 back to 1.
module t02_rr_picker #(
   parameter int N_PORTS = 3
) (
   input  logic [N_PORTS-1:1] req,
   input  logic [1:0]         ptr,
   output logic [N_PORTS-1:0] gnt_onehot,
   output logic [1:0]         gnt_idx,
   output logic               gnt_valid
);

   always_comb begin
      int cand;
      cand       = 0;
      gnt_onehot = '0;
      gnt_idx    = '0;
      gnt_valid  = 1'b0;
      for (int k = 0; k < N_PORTS - 1; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N_PORTS) begin
            cand = cand - (N_PORTS - 1);
         end
         for (int p = 1; p < N_PORTS; p++) begin
            if (!gnt_valid && req[p] && cand == p) begin
               gnt_valid     = 1'b1;
               gnt_idx       = 2'(p);
               gnt_onehot[p] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/t02_mem_arbiter.sv
// Shares one external RAM/wishbone port between requesters: port 0 has strict
// priority, the remaining ports are served round-robin, one transaction at a time.
module t02_mem_arbiter
   import t02_pkg::*;
#(
   parameter int N_PORTS = 3,
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic [N_PORTS-1:0]     m_req,
   input  logic [N_PORTS-1:0]     m_we,
   input  logic [N_PORTS*32-1:0]  m_addr,
   input  logic [N_PORTS*32-1:0]  m_wdata,
   input  logic [N_PORTS*4-1:0]   m_sel,
   output logic [N_PORTS-1:0]     m_done,
   output logic [31:0]            m_rdata,
   output logic                   bus_ren,
   output logic                   bus_wen,
   output logic [31:0]            bus_addr,
   output logic [31:0]            bus_wdata,
   output logic [3:0]             bus_sel,
   input  logic [31:0]            bus_rdata,
   input  logic                   busy_o,
   output logic [1:0]             gnt_id,
   output logic                   timeout_err
);

   localparam logic [ARB_CNT_W-1:0] WAIT_LAST = ARB_CNT_W'(TIMEOUT - 1);

   arb_state_t            state;
   logic                  we_q;
   logic [N_PORTS-1:0]    gnt_vec;
   logic [1:0]            rr_ptr;
   logic [ARB_CNT_W-1:0]  wait_cnt;

   logic [N_PORTS-1:0]    rr_vec;
   logic [1:0]            rr_idx;
   logic                  rr_valid;

   logic [N_PORTS-1:0]    pick_vec;
   logic [1:0]            pick_idx;
   logic                  pick_we;
   logic [31:0]           pick_addr;
   logic [31:0]           pick_wdata;
   logic [3:0]            pick_sel;

   t02_rr_picker #(.N_PORTS(N_PORTS)) u_rr_picker (
      .req        (m_req[N_PORTS-1:1]),
      .ptr        (rr_ptr),
      .gnt_onehot (rr_vec),
      .gnt_idx    (rr_idx),
      .gnt_valid  (rr_valid)
   );

   // Priority port overrides the round-robin choice; operands of the winner are muxed out.
   always_comb begin
      pick_vec   = '0;
      pick_idx   = '0;
      pick_we    = 1'b0;
      pick_addr  = '0;
      pick_wdata = '0;
      pick_sel   = '0;
      if (m_req[0]) begin
         pick_vec[0] = 1'b1;
         pick_idx    = 2'd0;
      end else if (rr_valid) begin
         pick_vec = rr_vec;
         pick_idx = rr_idx;
      end
      for (int p = 0; p < N_PORTS; p++) begin
         if (pick_idx == 2'(p)) begin
            pick_we    = m_we[p];
            pick_addr  = m_addr[32*p +: 32];
            pick_wdata = m_wdata[32*p +: 32];
            pick_sel   = m_sel[4*p +: 4];
         end
      end
   end

   // Strobes and done are state decodes so an async reset drops them immediately.
   assign bus_ren = (state == ARB_ISSUE) && !we_q;
   assign bus_wen = (state == ARB_ISSUE) && we_q;
   assign m_done  = (state == ARB_DONE) ? gnt_vec : '0;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= ARB_IDLE;
         we_q        <= 1'b0;
         gnt_vec     <= '0;
         gnt_id      <= '0;
         rr_ptr      <= 2'd1;
         wait_cnt    <= '0;
         bus_addr    <= '0;
         bus_wdata   <= '0;
         bus_sel     <= '0;
         m_rdata     <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (|m_req) begin
                  gnt_vec   <= pick_vec;
                  gnt_id    <= pick_idx;
                  we_q      <= pick_we;
                  bus_addr  <= pick_addr;
                  bus_wdata <= pick_wdata;
                  bus_sel   <= pick_sel;
                  state     <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               state <= ARB_SETTLE;
            end
            ARB_SETTLE: begin
               wait_cnt <= '0;
               state    <= ARB_WAIT;
            end
            // A normal finish on the last allowed cycle wins over the abort.
            ARB_WAIT: begin
               if (!busy_o) begin
                  if (!we_q) begin
                     m_rdata <= bus_rdata;
                  end
                  state <= ARB_DONE;
               end else if (wait_cnt == WAIT_LAST) begin
                  timeout_err <= 1'b1;
                  m_rdata     <= ARB_ERR_DATA;
                  state       <= ARB_DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ARB_DONE: begin
               if (gnt_id != 2'd0) begin
                  rr_ptr <= rr_next(gnt_id, N_PORTS);
               end
               state <= ARB_IDLE;
            end
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_t02_mem_arbiter.sv
// Directed bench for t02_mem_arbiter: read, write, priority/round-robin order,
// bus timeout, reset mid-transaction and back-to-back requests.
module tb_t02_mem_arbiter;

   localparam int N = 3;

   logic              clk = 1'b0;
   logic              nrst;
   logic [N-1:0]      m_req;
   logic [N-1:0]      m_we;
   logic [N*32-1:0]   m_addr;
   logic [N*32-1:0]   m_wdata;
   logic [N*4-1:0]    m_sel;
   logic [N-1:0]      m_done;
   logic [31:0]       m_rdata;
   logic              bus_ren;
   logic              bus_wen;
   logic [31:0]       bus_addr;
   logic [31:0]       bus_wdata;
   logic [3:0]        bus_sel;
   logic [31:0]       bus_rdata;
   logic              busy_o;
   logic [1:0]        gnt_id;
   logic              timeout_err;

   int passed = 0;
   int total  = 0;

   // Bus manager model: busy for busy_len cycles after a strobe, or stuck high.
   int busy_len;
   bit busy_stuck;
   int busy_cnt;

   // Scratch results of run_until_done, shared by the sequential test tasks.
   int          cyc, rn, wn;
   logic [2:0]  dv;
   logic [1:0]  gs;
   logic [31:0] sa, sw;
   logic [3:0]  ss;
   bit          hd;
   logic [107:0] out_all;

   always #5 clk = ~clk;

   always @(posedge clk or negedge nrst) begin
      if (!nrst) busy_cnt <= 0;
      else if (bus_ren || bus_wen) busy_cnt <= busy_len;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign busy_o = busy_stuck || (busy_cnt != 0);

   assign out_all = {m_done, m_rdata, bus_ren, bus_wen, bus_addr, bus_wdata, bus_sel, gnt_id, timeout_err};

   t02_mem_arbiter #(.N_PORTS(N), .TIMEOUT(255)) dut (
      .clk         (clk),
      .nrst        (nrst),
      .m_req       (m_req),
      .m_we        (m_we),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_sel       (m_sel),
      .m_done      (m_done),
      .m_rdata     (m_rdata),
      .bus_ren     (bus_ren),
      .bus_wen     (bus_wen),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_sel     (bus_sel),
      .bus_rdata   (bus_rdata),
      .busy_o      (busy_o),
      .gnt_id      (gnt_id),
      .timeout_err (timeout_err)
   );

   task automatic set_port(input int p, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] sel);
      m_we[p]             = we;
      m_addr[32*p +: 32]  = addr;
      m_wdata[32*p +: 32] = wdata;
      m_sel[4*p +: 4]     = sel;
   endtask

   // Steps negedges until any m_done or the cycle budget runs out, recording what the bus did.
   task automatic run_until_done(input int max_cycles, output int cycles, output logic [2:0] done_vec,
                                 output logic [1:0] gnt_seen, output int ren_n, output int wen_n,
                                 output logic [31:0] s_addr, output logic [31:0] s_wdata,
                                 output logic [3:0] s_sel, output bit held);
      bit seen;
      seen = 1'b0; cycles = 0; done_vec = '0; gnt_seen = '0; ren_n = 0; wen_n = 0;
      s_addr = '0; s_wdata = '0; s_sel = '0; held = 1'b1;
      while (cycles < max_cycles && done_vec == 3'b000) begin
         @(negedge clk);
         cycles++;
         if (bus_ren) ren_n++;
         if (bus_wen) wen_n++;
         if (!seen && (bus_ren || bus_wen)) begin
            seen = 1'b1; s_addr = bus_addr; s_wdata = bus_wdata; s_sel = bus_sel;
         end else if (seen && (bus_addr !== s_addr || bus_wdata !== s_wdata || bus_sel !== s_sel)) begin
            held = 1'b0;
         end
         done_vec = m_done;
         gnt_seen = gnt_id;
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_sel = '0;
      bus_rdata = '0; busy_len = 0; busy_stuck = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (out_all !== 108'd0) $display("[TB] FAIL reset_outputs: got %h expected 0", out_all); else passed++;
      nrst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (out_all !== 108'd0) $display("[TB] FAIL idle_outputs: got %h expected 0", out_all); else passed++;
   endtask

   task automatic test_single_read();
      busy_len = 3; bus_rdata = 32'h1234_5678;
      set_port(1, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
      m_req = 3'b010;
      run_until_done(20, cyc, dv, gs, rn, wn, sa, sw, ss, hd);
      m_req = '0;
      total++; if (dv !== 3'b010) $display("[TB] FAIL read_done: got %b expected 010", dv); else passed++;
      total++; if (cyc != 6) $display("[TB] FAIL read_latency: got %0d expected 6", cyc); else passed++;
      total++; if (rn != 1) $display("[TB] FAIL read_ren_cycles: got %0d expected 1", rn); else passed++;
      total++; if (wn != 0) $display("[TB] FAIL read_wen_cycles: got %0d expected 0", wn); else passed++;
      total++; if (sa !== 32'h40) $display("[TB] FAIL read_addr: got %h expected 00000040", sa); else passed++;
      total++; if (m_rdata !== 32'h1234_5678) $display("[TB] FAIL read_data: got %h expected 12345678", m_rdata); else passed++;
      total++; if (gs !== 2'd1) $display("[TB] FAIL read_gnt: got %0d expected 1", gs); else passed++;
      @(negedge clk);
      total++; if (m_done !== 3'b000) $display("[TB] FAIL read_done_once: got %b expected 000", m_done); else passed++;
   endtask

   task automatic test_write();
      busy_len = 2; bus_rdata = 32'hFFFF_0000;
      set_port(2, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 4'b1111);
      m_req = 3'b100;
      run_until_done(20, cyc, dv, gs, rn, wn, sa, sw, ss, hd);
      m_req = '0;
      total++; if (dv !== 3'b100) $display("[TB] FAIL write_done: got %b expected 100", dv); else passed++;
      total++; if (cyc != 5) $display("[TB] FAIL write_latency: got %0d expected 5", cyc); else passed++;
      total++; if (wn != 1) $display("[TB] FAIL write_wen_cycles: got %0d expected 1", wn); else passed++;
      total++; if (rn != 0) $display("[TB] FAIL write_ren_cycles: got %0d expected 0", rn); else passed++;
      total++; if ({sa, sw, ss} !== {32'h80, 32'hCAFE_F00D, 4'hF})
         $display("[TB] FAIL write_operands: got %h %h %h expected 00000080 cafef00d f", sa, sw, ss); else passed++;
      total++; if (hd !== 1'b1) $display("[TB] FAIL write_operands_held: got %b expected 1", hd); else passed++;
      total++; if (m_rdata !== 32'h1234_5678) $display("[TB] FAIL write_rdata_kept: got %h expected 12345678", m_rdata); else passed++;
      total++; if (gs !== 2'd2) $display("[TB] FAIL write_gnt: got %0d expected 2", gs); else passed++;
      @(negedge clk);
   endtask

   task automatic test_priority();
      logic [1:0]  exp_port [5];
      logic [2:0]  exp_vec;
      logic [31:0] exp_addr;
      exp_port = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2};
      busy_len = 0; bus_rdata = 32'h0;
      set_port(0, 1'b0, 32'h100, 32'h0, 4'hF);
      set_port(1, 1'b0, 32'h104, 32'h0, 4'hF);
      set_port(2, 1'b0, 32'h108, 32'h0, 4'hF);
      m_req = 3'b111;
      for (int i = 0; i < 5; i++) begin
         run_until_done(20, cyc, dv, gs, rn, wn, sa, sw, ss, hd);
         if (i == 0) m_req[0] = 1'b0;
         if (i == 4) m_req = '0;
         exp_vec  = 3'b001 << exp_port[i];
         exp_addr = 32'h100 + 32'(exp_port[i]) * 4;
         total++; if (dv !== exp_vec) $display("[TB] FAIL prio_done[%0d]: got %b expected %b", i, dv, exp_vec); else passed++;
         total++; if (gs !== exp_port[i]) $display("[TB] FAIL prio_gnt[%0d]: got %0d expected %0d", i, gs, exp_port[i]); else passed++;
         total++; if (sa !== exp_addr) $display("[TB] FAIL prio_addr[%0d]: got %h expected %h", i, sa, exp_addr); else passed++;
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      total++; if (timeout_err !== 1'b0) $display("[TB] FAIL timeout_err_clear: got %b expected 0", timeout_err); else passed++;
      busy_stuck = 1'b1; bus_rdata = 32'h55AA_55AA;
      set_port(1, 1'b0, 32'h200, 32'h0, 4'hF);
      m_req = 3'b010;
      run_until_done(400, cyc, dv, gs, rn, wn, sa, sw, ss, hd);
      m_req = '0;
      busy_stuck = 1'b0;
      // ISSUE + SETTLE + 255 WAIT cycles + DONE
      total++; if (dv !== 3'b010) $display("[TB] FAIL timeout_done: got %b expected 010", dv); else passed++;
      total++; if (cyc != 258) $display("[TB] FAIL timeout_latency: got %0d expected 258", cyc); else passed++;
      total++; if (timeout_err !== 1'b1) $display("[TB] FAIL timeout_err_set: got %b expected 1", timeout_err); else passed++;
      total++; if (m_rdata !== 32'hDEAD_BEEF) $display("[TB] FAIL timeout_data: got %h expected deadbeef", m_rdata); else passed++;
      @(negedge clk);
      busy_len = 1; bus_rdata = 32'h0BAD_CAFE;
      set_port(2, 1'b0, 32'h204, 32'h0, 4'hF);
      m_req = 3'b100;
      run_until_done(20, cyc, dv, gs, rn, wn, sa, sw, ss, hd);
      m_req = '0;
      total++; if (dv !== 3'b100) $display("[TB] FAIL after_timeout_done: got %b expected 100", dv); else passed++;
      total++; if (cyc != 4) $display("[TB] FAIL after_timeout_latency: got %0d expected 4", cyc); else passed++;
      total++; if (m_rdata !== 32'h0BAD_CAFE) $display("[TB] FAIL after_timeout_data: got %h expected 0badcafe", m_rdata); else passed++;
      total++; if (timeout_err !== 1'b1) $display("[TB] FAIL timeout_err_sticky: got %b expected 1", timeout_err); else passed++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [2:0] done_seen;
      busy_len = 10; bus_rdata = 32'h1111_1111;
      set_port(1, 1'b0, 32'h300, 32'h0, 4'hF);
      m_req = 3'b010;
      repeat (3) @(negedge clk);
      #2 nrst = 1'b0;
      #1;
      total++; if (out_all !== 108'd0) $display("[TB] FAIL reset_mid_outputs: got %h expected 0", out_all); else passed++;
      done_seen = '0;
      repeat (3) begin
         @(negedge clk);
         done_seen = done_seen | m_done;
      end
      total++; if (done_seen !== 3'b000) $display("[TB] FAIL reset_mid_no_done: got %b expected 000", done_seen); else passed++;
      busy_len = 0; bus_rdata = 32'h2222_2222;
      nrst = 1'b1;
      run_until_done(20, cyc, dv, gs, rn, wn, sa, sw, ss, hd);
      m_req = '0;
      total++; if (dv !== 3'b010) $display("[TB] FAIL post_reset_done: got %b expected 010", dv); else passed++;
      total++; if (cyc != 4) $display("[TB] FAIL post_reset_latency: got %0d expected 4", cyc); else passed++;
      total++; if (m_rdata !== 32'h2222_2222) $display("[TB] FAIL post_reset_data: got %h expected 22222222", m_rdata); else passed++;
      total++; if (timeout_err !== 1'b0) $display("[TB] FAIL post_reset_err: got %b expected 0", timeout_err); else passed++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      busy_len = 0; bus_rdata = 32'hA5A5_0001;
      set_port(1, 1'b0, 32'h400, 32'h0, 4'hF);
      m_req = 3'b010;
      run_until_done(20, cyc, dv, gs, rn, wn, sa, sw, ss, hd);
      total++; if ({dv, m_rdata} !== {3'b010, 32'hA5A5_0001})
         $display("[TB] FAIL b2b_first: got %b %h expected 010 a5a50001", dv, m_rdata); else passed++;
      set_port(1, 1'b0, 32'h404, 32'h0, 4'hF);
      bus_rdata = 32'hA5A5_0002;
      @(negedge clk);
      total++; if (m_rdata !== 32'hA5A5_0001) $display("[TB] FAIL b2b_rdata_held: got %h expected a5a50001", m_rdata); else passed++;
      run_until_done(20, cyc, dv, gs, rn, wn, sa, sw, ss, hd);
      m_req = '0;
      total++; if (dv !== 3'b010) $display("[TB] FAIL b2b_second_done: got %b expected 010", dv); else passed++;
      total++; if (cyc != 4) $display("[TB] FAIL b2b_latency: got %0d expected 4", cyc); else passed++;
      total++; if (sa !== 32'h404) $display("[TB] FAIL b2b_addr: got %h expected 00000404", sa); else passed++;
      total++; if (m_rdata !== 32'hA5A5_0002) $display("[TB] FAIL b2b_second_data: got %h expected a5a50002", m_rdata); else passed++;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write();
      test_priority();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
